// File: rtl/osg_channel_sequencer_if.sv
// Config bus and control/status bundle for osg_channel_sequencer.
// Optional repeat count port is present only when OSG_SEQ_REPEAT_EN is defined.
interface osg_channel_sequencer_if #(
    parameter int N_CH   = 16,
    parameter int CNT_W  = 17,
    parameter int MULT_W = 5
);
    localparam int CH_W = $clog2(N_CH);

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [1:0]        cfg_sel;
    logic [CNT_W-1:0]  cfg_data;
    logic              cfg_err;
    logic              start;
    logic              abort;
`ifdef OSG_SEQ_REPEAT_EN
    logic [7:0]        rep;
`endif
    logic [N_CH-1:0]   ch_out;
    logic              busy;
    logic [CH_W-1:0]   cur_ch;
    logic              end_flg;

    modport master (
`ifdef OSG_SEQ_REPEAT_EN
        output rep,
`endif
        output cfg_we, cfg_ch, cfg_sel, cfg_data, start, abort,
        input  cfg_err, ch_out, busy, cur_ch, end_flg
    );

    modport slave (
`ifdef OSG_SEQ_REPEAT_EN
        input  rep,
`endif
        input  cfg_we, cfg_ch, cfg_sel, cfg_data, start, abort,
        output cfg_err, ch_out, busy, cur_ch, end_flg
    );
endinterface

// File: rtl/osg_channel_sequencer.sv
// Shared-timer channel sequencer: walks channels 0..N_CH-1 with per-channel pulse/delay phases.
// Define OSG_SEQ_REPEAT_EN to run the full walk rep+1 times per start.
module osg_channel_sequencer #(
    parameter int N_CH   = 16,
    parameter int CNT_W  = 17,
    parameter int MULT_W = 5
) (
    input logic                    clk,
    input logic                    rst,
    osg_channel_sequencer_if.slave bus
);
    localparam int CH_W = $clog2(N_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_DELAY, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
    logic [CNT_W-1:0]   tick_q, tick_d;
    logic [MULT_W-1:0]  pre_q, pre_d;
    logic [MULT_W-1:0]  mult_q, mult_d;
    logic [7:0]         pass_q, pass_d;
    logic [N_CH-1:0]    ch_out_q, ch_out_d;
    logic               busy_q, busy_d;
    logic               end_flg_q, end_flg_d;
    logic               cfg_err_q, cfg_err_d;

    logic [CNT_W-1:0]   dur_q [N_CH];
    logic [CNT_W-1:0]   dur_d [N_CH];
    logic [CNT_W-1:0]   del_q [N_CH];
    logic [CNT_W-1:0]   del_d [N_CH];
    logic [MULT_W-1:0]  mpl_q [N_CH];
    logic [MULT_W-1:0]  mpl_d [N_CH];
    logic [MULT_W-1:0]  mdl_q [N_CH];
    logic [MULT_W-1:0]  mdl_d [N_CH];

    logic [7:0]         rep_in;
    logic               expire;
    logic               enter_pulse;
    logic [CH_W-1:0]    pulse_ch;

`ifdef OSG_SEQ_REPEAT_EN
    assign rep_in = bus.rep;
`else
    assign rep_in = 8'd0;
`endif

    // A phase of field value 0 expires in its first cycle regardless of the prescaler.
    assign expire = (tick_q == '0) || ((tick_q == CNT_W'(1)) && (pre_q == '0));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        tick_d      = tick_q;
        pre_d       = pre_q;
        mult_d      = mult_q;
        pass_d      = pass_q;
        ch_out_d    = ch_out_q;
        busy_d      = busy_q;
        end_flg_d   = 1'b0;
        cfg_err_d   = 1'b0;
        enter_pulse = 1'b0;
        pulse_ch    = '0;
        dur_d       = dur_q;
        del_d       = del_q;
        mpl_d       = mpl_q;
        mdl_d       = mdl_q;

        if (bus.cfg_we) begin
            if (state_q == S_IDLE || state_q == S_DONE) begin
                unique case (bus.cfg_sel)
                    2'd0: dur_d[bus.cfg_ch] = bus.cfg_data;
                    2'd1: del_d[bus.cfg_ch] = bus.cfg_data;
                    2'd2: mpl_d[bus.cfg_ch] = bus.cfg_data[MULT_W-1:0];
                    default: mdl_d[bus.cfg_ch] = bus.cfg_data[MULT_W-1:0];
                endcase
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d     = S_PULSE;
                    busy_d      = 1'b1;
                    pass_d      = rep_in;
                    enter_pulse = 1'b1;
                end
            end
            S_PULSE, S_DELAY: begin
                if (bus.abort) begin
                    state_d  = S_IDLE;
                    ch_out_d = '0;
                    busy_d   = 1'b0;
                    cur_ch_d = '0;
                end else if (!expire) begin
                    if (pre_q == '0) begin
                        tick_d = tick_q - 1'b1;
                        pre_d  = mult_q;
                    end else begin
                        pre_d = pre_q - 1'b1;
                    end
                end else if (state_q == S_PULSE) begin
                    state_d  = S_DELAY;
                    ch_out_d = '0;
                    tick_d   = del_q[cur_ch_q];
                    pre_d    = mdl_q[cur_ch_q];
                    mult_d   = mdl_q[cur_ch_q];
                end else if (cur_ch_q != LAST_CH) begin
                    state_d     = S_PULSE;
                    enter_pulse = 1'b1;
                    pulse_ch    = cur_ch_q + 1'b1;
                end else if (pass_q != '0) begin
                    state_d     = S_PULSE;
                    pass_d      = pass_q - 1'b1;
                    enter_pulse = 1'b1;
                end else begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    end_flg_d = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                cur_ch_d = '0;
            end
        endcase

        if (enter_pulse) begin
            cur_ch_d           = pulse_ch;
            tick_d             = dur_q[pulse_ch];
            pre_d              = mpl_q[pulse_ch];
            mult_d             = mpl_q[pulse_ch];
            ch_out_d           = '0;
            ch_out_d[pulse_ch] = (dur_q[pulse_ch] != '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cur_ch_q  <= '0;
            tick_q    <= '0;
            pre_q     <= '0;
            mult_q    <= '0;
            pass_q    <= '0;
            ch_out_q  <= '0;
            busy_q    <= 1'b0;
            end_flg_q <= 1'b0;
            cfg_err_q <= 1'b0;
            // NOTE: the config file is reset explicitly because a cleared table is a defined start state.
            for (int i = 0; i < N_CH; i++) begin
                dur_q[i] <= '0;
                del_q[i] <= '0;
                mpl_q[i] <= '0;
                mdl_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cur_ch_q  <= cur_ch_d;
            tick_q    <= tick_d;
            pre_q     <= pre_d;
            mult_q    <= mult_d;
            pass_q    <= pass_d;
            ch_out_q  <= ch_out_d;
            busy_q    <= busy_d;
            end_flg_q <= end_flg_d;
            cfg_err_q <= cfg_err_d;
            dur_q     <= dur_d;
            del_q     <= del_d;
            mpl_q     <= mpl_d;
            mdl_q     <= mdl_d;
        end
    end

    assign bus.ch_out  = ch_out_q;
    assign bus.busy    = busy_q;
    assign bus.cur_ch  = cur_ch_q;
    assign bus.end_flg = end_flg_q;
    assign bus.cfg_err = cfg_err_q;
endmodule

// File: tb/tb_osg_channel_sequencer.sv
// Directed bench for osg_channel_sequencer with hand-computed cycle-by-cycle expectations.
module tb_osg_channel_sequencer;
    localparam int N_CH   = 16;
    localparam int CNT_W  = 17;
    localparam int MULT_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    osg_channel_sequencer_if #(.N_CH(N_CH), .CNT_W(CNT_W), .MULT_W(MULT_W)) bus ();

    osg_channel_sequencer #(.N_CH(N_CH), .CNT_W(CNT_W), .MULT_W(MULT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1ns after the rising edge; inputs set here are seen at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int sel, input int data);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 4'(ch);
        bus.cfg_sel  = 2'(sel);
        bus.cfg_data = 17'(data);
        step();
        bus.cfg_we   = 1'b0;
    endtask

    // Starts a run and steps until end_flg (left sitting in the DONE cycle) or budget runs out.
    task automatic run(input int budget, output int hi0, output bit seen);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        hi0  = int'(bus.ch_out[0]);
        seen = bus.end_flg;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (bus.ch_out[0]) hi0++;
            if (bus.end_flg) seen = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int hi0;
        bit seen;

        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_sel = '0; bus.cfg_data = '0;
        bus.start = 1'b0; bus.abort = 1'b0;
`ifdef OSG_SEQ_REPEAT_EN
        bus.rep = 8'd0;
`endif
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_ch_out",  bus.ch_out,  0);
        check("rst_busy",    bus.busy,    0);
        check("rst_cur_ch",  bus.cur_ch,  0);
        check("rst_end_flg", bus.end_flg, 0);
        check("rst_cfg_err", bus.cfg_err, 0);

        // ch0: dur=3 mp=0 del=2 md=1, rest 0
        cfg_write(0, 0, 3);
        cfg_write(0, 1, 2);
        cfg_write(0, 2, 0);
        cfg_write(0, 3, 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            check("t1_ch_out", bus.ch_out, (k <= 3) ? 1 : 0);
            check("t1_busy", bus.busy, (k <= 37) ? 1 : 0);
            check("t1_end", bus.end_flg, (k == 38) ? 1 : 0);
            if (k == 4)  check("t1_cur_ch4", bus.cur_ch, 0);
            if (k == 8)  check("t1_cur_ch8", bus.cur_ch, 1);
            if (k == 37) check("t1_cur_ch37", bus.cur_ch, 15);
            step();
        end

        // reset clears the table; ch5: dur=4 mp=2 only
        rst = 1'b1;
        step();
        rst = 1'b0;
        cfg_write(5, 0, 4);
        cfg_write(5, 2, 2);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 46; k++) begin
            check("t2_ch_out", bus.ch_out, (k >= 11 && k <= 22) ? 64'h20 : 0);
            check("t2_end", bus.end_flg, (k == 44) ? 1 : 0);
            step();
        end

        // abort on the 3rd pulse cycle of ch0 (dur=10)
        rst = 1'b1;
        step();
        rst = 1'b0;
        cfg_write(0, 0, 10);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        check("t3_pre_abort", bus.ch_out, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("t3_ab_ch_out", bus.ch_out, 0);
        check("t3_ab_busy",   bus.busy,   0);
        check("t3_ab_cur_ch", bus.cur_ch, 0);
        for (int k = 0; k < 40; k++) begin
            check("t3_no_end", bus.end_flg, 0);
            step();
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("t3_rerun_ch0",  bus.ch_out, 1);
        check("t3_rerun_busy", bus.busy,   1);
        // reset mid-sequence
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t3_rst_busy",   bus.busy,   0);
        check("t3_rst_ch_out", bus.ch_out, 0);
        check("t3_rst_end",    bus.end_flg, 0);

        // write while busy is dropped; write during DONE is accepted
        cfg_write(0, 0, 2);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.cfg_we = 1'b1; bus.cfg_ch = '0; bus.cfg_sel = 2'd0; bus.cfg_data = 17'd7;
        step();
        bus.cfg_we = 1'b0;
        check("t4_cfg_err_hi", bus.cfg_err, 1);
        step();
        check("t4_cfg_err_lo", bus.cfg_err, 0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            if (bus.end_flg) seen = 1'b1;
        end
        check("t4_runA_end", seen, 1);
        step();
        run(60, hi0, seen);
        check("t4_runB_end", seen, 1);
        check("t4_runB_len", hi0, 2);
        bus.cfg_we = 1'b1; bus.cfg_ch = '0; bus.cfg_sel = 2'd0; bus.cfg_data = 17'd5;
        step();
        bus.cfg_we = 1'b0;
        check("t4_done_wr_err", bus.cfg_err, 0);
        run(60, hi0, seen);
        check("t4_runC_end", seen, 1);
        check("t4_runC_len", hi0, 5);
        step();

        // start held high, all fields zero
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.start = 1'b1;
        step();
        for (int k = 1; k <= 36; k++) begin
            check("t5_ch_out", bus.ch_out, 0);
            check("t5_busy", bus.busy, ((k <= 32) || (k >= 35)) ? 1 : 0);
            check("t5_end", bus.end_flg, (k == 33) ? 1 : 0);
            step();
        end
        bus.start = 1'b0;

`ifdef OSG_SEQ_REPEAT_EN
        // three passes of a one-cycle ch0 pulse
        rst = 1'b1;
        step();
        rst = 1'b0;
        cfg_write(0, 0, 1);
        bus.rep   = 8'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.rep   = 8'd0;
        for (int k = 1; k <= 98; k++) begin
            check("t6_ch_out", bus.ch_out, (k == 1 || k == 33 || k == 65) ? 1 : 0);
            check("t6_busy", bus.busy, (k <= 96) ? 1 : 0);
            check("t6_end", bus.end_flg, (k == 97) ? 1 : 0);
            step();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/osg_channel_sequencer.md
Name: osg_channel_sequencer

Overview:
- Centralised timing controller for the optical-clock-pulse generator. It replaces the per-channel chained pulse/delay counters with one shared phase timer.
- Holds per-channel pulse duration, post-pulse delay and prescale multipliers in a register file written by the UART/RAM loader.
- On start, walks channels 0..N_CH-1 in order: asserts each channel output for its scaled duration, then waits its scaled delay.
- Emits a one-cycle end flag after the last channel, for the start/stop logic.

Parameters:
- N_CH, 16, number of output channels (power of 2, 2..16)
- CNT_W, 17, width of duration/delay fields
- MULT_W, 5, width of prescale multiplier fields

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  config write strobe
- cfg_ch  in  log2(N_CH)  target channel
- cfg_sel  in  2  field select: 0=duration, 1=delay, 2=pulse mult, 3=delay mult
- cfg_data  in  CNT_W  write data (mult fields take low MULT_W bits)
- start  in  1  level, sampled each cycle
- abort  in  1  level, sampled each cycle
- ch_out  out  N_CH  channel pulse outputs, one-hot or zero
- busy  out  1  high while sequence is running
- cur_ch  out  log2(N_CH)  channel currently being sequenced
- end_flg  out  1  one-cycle pulse on normal completion
- cfg_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - all config fields cleared to 0; state IDLE
  - ch_out=0, busy=0, cur_ch=0, end_flg=0, cfg_err=0
  - rst mid-sequence aborts immediately; no end_flg
- Phase length:
  - pulse phase = dur*(mult_pl+1) clocks; delay phase = del*(mult_dl+1) clocks
  - implemented as a prescale counter plus a CNT_W tick counter; no multiplier
  - a field value of 0 gives a phase of exactly 1 clock with ch_out=0
- State IDLE:
  - start=1 and abort=0 → PULSE with cur_ch=0, busy=1 from the next cycle
  - start is level-sensitive and ignored while not IDLE
- State PULSE:
  - ch_out[cur_ch]=1, all other bits 0 (forced 0 if dur=0)
  - when the phase expires → DELAY, with ch_out cleared in the same transition
- State DELAY:
  - ch_out=0
  - on expiry: if cur_ch<N_CH-1 → cur_ch+1 and PULSE; else → DONE
  - the delay of the last channel is applied
- State DONE:
  - end_flg=1 and busy=0 for one cycle, then IDLE
  - a start asserted during DONE is not accepted until IDLE
- abort=1 in PULSE/DELAY:
  - next cycle IDLE; ch_out=0, busy=0, cur_ch=0; no end_flg
  - abort has priority over phase expiry and over start
- Config writes:
  - accepted only in IDLE or DONE; take effect on the next cycle
  - cfg_we while busy=1: write dropped, cfg_err pulses 1 cycle
- Latency: start sampled at edge T → ch_out[0] rises at T+1 (registered outputs).
- cur_ch wraps never; the counter saturates at N_CH-1 before DONE.

Optional Feature:
- Macro OSG_SEQ_REPEAT_EN.
- Defined:
  - adds input rep, 8 bits, sampled when start is accepted
  - the full channel walk runs rep+1 times back-to-back: after channel N_CH-1 DELAY expires, go to PULSE with cur_ch=0 until passes are exhausted
  - busy stays high across passes; end_flg only after the final pass
  - abort stops immediately
- Not defined: no rep port; single pass only.

Test Plan:
- Reset then ch0: dur=3, mp=0, del=2, md=1; others 0; start at T.
  - ch_out[0]=1 on T+1..T+3; delay on T+4..T+7
  - ch1..ch15 take 2 cycles each (T+8..T+37); end_flg=1 at T+38 only; busy=0 at T+38
- ch5: dur=4, mp=2; others 0.
  - ch_out[5] high exactly 12 consecutive cycles; no other bit set at any time
- abort at 3rd cycle of ch0 pulse (dur=10).
  - ch_out=0 and busy=0 next cycle; end_flg never asserts; a new start reruns from ch0
- cfg_we while busy=1.
  - cfg_err=1 for one cycle; the field keeps its old value in the following run
  - a write during DONE is accepted
- start held high continuously with all fields 0.
  - sequence of 32 cycles, end_flg, 1 IDLE cycle, restart; ch_out stays 0 throughout
- OSG_SEQ_REPEAT_EN, rep=2, ch0 dur=1, others 0.
  - ch_out[0] pulses 3 times, 32 cycles apart; a single end_flg after the third pass
